// File: rtl/multiplier_seq_hs_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/multiplier_seq_hs_if.sv
// Operand/product handshake bundle for multiplier_seq_hs.
interface multiplier_seq_hs_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] P;
    logic               busy;

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P, busy
    );

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P, busy
    );
endinterface

// File: rtl/multiplier_seq_hs_step.sv
// One combinational shift-and-add iteration.
module mult_shift_add_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);
    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;
endmodule

// File: rtl/multiplier_seq_hs.sv
// Sequential unsigned multiplier: accept (A, B), iterate WIDTH times, hold P until taken.
module multiplier_seq_hs
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input logic                clk,
    input logic                rst,
    multiplier_seq_hs_if.slave bus
);
    localparam int unsigned     CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mult_state_t        state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2*WIDTH-1:0] acc_step, mcand_step;
    logic [WIDTH-1:0]   mplier_step;

    mult_shift_add_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .acc_next   (acc_step),
        .mcand_next (mcand_step),
        .mplier_next(mplier_step)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone completes the handshake
                if (bus.in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_step;
                mplier_d = mplier_step;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    p_d     = acc_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.P         = p_q;
endmodule

// File: tb/tb_multiplier_seq_hs.sv
// Directed self-checking bench for multiplier_seq_hs at WIDTH=2 and WIDTH=8.
module tb_multiplier_seq_hs;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    multiplier_seq_hs_if #(.WIDTH(2)) if2 ();
    multiplier_seq_hs_if #(.WIDTH(8)) if8 ();

    multiplier_seq_hs #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    multiplier_seq_hs #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream vectors and hand-computed products for the WIDTH=2 back-to-back test
    logic [1:0] sa [20] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0,
                            2'd3, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
    logic [1:0] sb [20] = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0,
                            2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [3:0] sp [20] = '{4'd9, 4'd4, 4'd4, 4'd3, 4'd0, 4'd3, 4'd6, 4'd6, 4'd1, 4'd0,
                            4'd0, 4'd2, 4'd2, 4'd9, 4'd0, 4'd4, 4'd0, 4'd3, 4'd3, 4'd6};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Full WIDTH=8 transaction with out_ready=1; latency counted from the accept cycle
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input string tag);
        int lat;
        @(negedge clk);
        if8.A = a;
        if8.B = b;
        if8.in_valid  = 1'b1;
        if8.out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, 32'(if8.in_ready), 32'd1);
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 1;
        while (!if8.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd9);
        check_eq({tag, "_P"}, 32'(if8.P), 32'(exp));
        @(negedge clk);
        check_eq({tag, "_idle"}, {29'd0, if8.in_ready, if8.out_valid, if8.busy}, 32'b100);
    endtask

    initial begin
        int lat;
        int bad;
        int idx;
        int k;
        int cyc;
        int last_acc;
        bit pending;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        if2.in_valid = 1'b0; if2.A = '0; if2.B = '0; if2.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.A = '0; if8.B = '0; if8.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst2_flags", {29'd0, if2.in_ready, if2.out_valid, if2.busy}, 32'b100);
        check_eq("rst2_P", 32'(if2.P), 32'd0);
        check_eq("rst8_flags", {29'd0, if8.in_ready, if8.out_valid, if8.busy}, 32'b100);
        check_eq("rst8_P", 32'(if8.P), 32'd0);
        rst = 1'b0;

        // WIDTH=2: 3*3, out_valid in cycle 3 after the accept cycle
        @(negedge clk);
        if2.A = 2'd3; if2.B = 2'd3; if2.in_valid = 1'b1; if2.out_ready = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
        lat = 1;
        while (!if2.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("w2_latency", 32'(lat), 32'd3);
        check_eq("w2_P", 32'(if2.P), 32'd9);
        check_eq("w2_no_bypass", 32'(if2.in_ready), 32'd0);
        @(negedge clk);
        check_eq("w2_idle", {29'd0, if2.in_ready, if2.out_valid, if2.busy}, 32'b100);
        check_eq("w2_P_kept", 32'(if2.P), 32'd9);

        // WIDTH=8 corners
        run8(8'd255, 8'd255, 16'd65025, "c_255x255");
        run8(8'd0,   8'd200, 16'd0,     "c_0x200");
        run8(8'd1,   8'd1,   16'd1,     "c_1x1");
        run8(8'd128, 8'd2,   16'd256,   "c_128x2");

        // Backpressure: 12*11 held for 20 cycles, stray in_valid pulse ignored
        @(negedge clk);
        if8.A = 8'd12; if8.B = 8'd11; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
        @(negedge clk);
        if8.in_valid = 1'b0;
        if8.A = 8'd99; if8.B = 8'd99;
        lat = 1;
        while (!if8.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("bp_latency", 32'(lat), 32'd9);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!if8.out_valid || if8.P !== 16'd132 || if8.in_ready || !if8.busy) bad++;
            if8.in_valid = (i == 5);
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        check_eq("bp_hold_bad_cycles", 32'(bad), 32'd0);
        check_eq("bp_P", 32'(if8.P), 32'd132);
        if8.out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_idle", {29'd0, if8.in_ready, if8.out_valid, if8.busy}, 32'b100);
        check_eq("bp_P_kept", 32'(if8.P), 32'd132);

        // Reset during the fourth CALC iteration of 200*3
        @(negedge clk);
        if8.A = 8'd200; if8.B = 8'd3; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rmid_busy", 32'(if8.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rmid_flags", {29'd0, if8.in_ready, if8.out_valid, if8.busy}, 32'b100);
        check_eq("rmid_P", 32'(if8.P), 32'd0);
        run8(8'd5, 8'd7, 16'd35, "rmid_5x7");

        // WIDTH=2 back-to-back stream with in_valid held high
        @(negedge clk);
        idx = 0; k = 0; cyc = 0; last_acc = -1; pending = 1'b0;
        if2.A = sa[0]; if2.B = sb[0]; if2.in_valid = 1'b1; if2.out_ready = 1'b1;
        while (k < 20 && cyc < 300) begin
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx < 20) begin
                    if2.A = sa[idx];
                    if2.B = sb[idx];
                end else begin
                    if2.in_valid = 1'b0;
                end
            end
            if (if2.out_valid) begin
                check_eq($sformatf("b2b_P%0d", k), 32'(if2.P), 32'(sp[k]));
                k++;
            end
            if (if2.in_valid && if2.in_ready) begin
                if (last_acc >= 0) check_eq($sformatf("b2b_ii%0d", idx), 32'(cyc - last_acc), 32'd4);
                last_acc = cyc;
                pending  = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("b2b_count", 32'(k), 32'd20);
        check_eq("b2b_accepts", 32'(idx), 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier_seq_hs.md
Name: multiplier_seq_hs

Overview:
- Sequential shift-and-add unsigned multiplier with valid/ready handshakes on operand input and product output.
- Responder counterpart to the operand-driving benches. It accepts an (A, B) pair, computes P = A*B over WIDTH iterations, and holds P until the consumer takes it.
- Drop-in alternative to the combinational multiplier where area matters more than latency. The RL exploration flow sweeps WIDTH.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair A/B valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  multiplicand, unsigned
- B  input  WIDTH  multiplier, unsigned
- out_valid  output  1  P holds a completed product
- out_ready  input  1  consumer accepts P
- P  output  2*WIDTH  product, unsigned
- busy  output  1  high in CALC or DONE

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst, sampled at the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, P=0, counter=0, internal registers=0.
- rst overrides everything, including mid-CALC and DONE. An in-flight product is discarded with no out_valid pulse.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - Accept when in_valid && in_ready at an edge. Latch mcand={WIDTH'b0,A}, mplier=B and acc=0, clear counter, go to CALC.
  - in_valid without a handshake has no effect.
- CALC:
  - in_ready=0.
  - Each cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, counter++.
  - Exactly WIDTH iterations, with no early termination, so latency is fixed.
  - On the edge completing iteration WIDTH: P <= final acc and go to DONE.
- DONE:
  - out_valid=1 and P stable.
  - If out_ready at the edge, go to IDLE; out_valid drops and in_ready rises on the next cycle.
  - While out_ready=0, hold indefinitely with P and out_valid unchanged.
- Timing: with the accept edge at cycle 0, out_valid is first high in cycle WIDTH+1. Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH iterations, one DONE cycle with out_ready=1).
- No same-cycle bypass: in_ready is never high while out_valid is high.
- Arithmetic: acc is 2*WIDTH bits and cannot overflow, since max (2^W-1)^2 < 2^(2W). All values are unsigned, with no sign extension.
- P keeps the last product after leaving DONE. It changes only on CALC→DONE or on reset.
- A and B are sampled only at the accept edge. Later changes are ignored.
- in_valid high while busy is ignored. The source must hold in_valid until in_ready. in_valid must not depend combinationally on in_ready.

Decomposition:
- Package mult_pkg:
  - state enum type mult_state_t with values IDLE, CALC, DONE;
  - default WIDTH constant.
- One sub-module, mult_shift_add_step. It is combinational: (acc, mcand, mplier) → next (acc, mcand, mplier) for one iteration. The top holds the FSM, counter and registers.

Test Plan:
- WIDTH=2, A=3, B=3, out_ready=1 → out_valid high exactly 3 cycles after accept; P=9; in_ready back 1 cycle after the DONE handshake.
- WIDTH=8 corners: (255,255)→65025, (0,200)→0, (1,1)→1, (128,2)→256. Check each P against a reference model; latency is 9 cycles in every case.
- Backpressure: WIDTH=8, A=12, B=11, out_ready=0 for 20 cycles, then 1 → P=132 held stable, out_valid high throughout; in_ready stays 0 and an in_valid pulse is ignored; IDLE after the handshake.
- Reset mid-operation: accept (200,3), assert rst in CALC iteration 4 → next cycle in_ready=1, out_valid=0, P=0. A following (5,7) yields 35 with nominal latency.
- Back-to-back: in_valid held high with out_ready=1, streaming the 20-pair 2-bit sequence (3,3),(2,2),(2,2),(1,3),... → products 9,4,4,3,... in order, one result per WIDTH+2 cycles, none dropped or duplicated.
